// File: rtl/k_alu_sched.sv
// Two-requester round-robin scheduler for one shared K-series 32-bit ALU.
// Define K_ALU_SCHED_FIXED_PRIO_EN to make req0 win every contended grant.
module k_alu_sched #(
  parameter int TAG_W   = 4,
  parameter int ALU_LAT = 1,
  parameter int DIV_LAT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [2:0]       alu_sel,
  output logic             alu_enable,
  output logic [31:0]      alu_op_a,
  output logic [31:0]      alu_op_b,
  input  logic [31:0]      alu_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_src,
  output logic             wb_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid and payload are held by the source until then.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  localparam int MAX_LAT = (DIV_LAT > ALU_LAT) ? DIV_LAT : ALU_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_r;
  logic [31:0]        a_r, b_r, data_r;
  logic [TAG_W-1:0]   tag_r;
  logic               src_r, err_r;

  logic               grant, accept, illegal, div0;
  logic [2:0]         sel_op;
  logic [31:0]        sel_a, sel_b;
  logic [TAG_W-1:0]   sel_tag;

`ifdef K_ALU_SCHED_FIXED_PRIO_EN
  always_comb begin
    grant = req1_valid & ~req0_valid;
  end
`else
  logic last_grant;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  // Starts at 1 so req0 wins the first contended grant after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`endif

  // Readies are gated by rst_n so every output is 0 while reset is held.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready | req1_ready;

  assign sel_op  = grant ? req1_op  : req0_op;
  assign sel_a   = grant ? req1_a   : req0_a;
  assign sel_b   = grant ? req1_b   : req0_b;
  assign sel_tag = grant ? req1_tag : req0_tag;
  assign illegal = (sel_op[2:1] == 2'b11);
  assign div0    = (sel_op == 3'b100) && (sel_b == 32'd0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = (illegal || div0) ? RESP : EXEC;
      EXEC: if (cnt == '0) state_nx = RESP;
      RESP: if (wb_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      tag_r  <= '0;
      src_r  <= 1'b0;
      data_r <= '0;
      err_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r  <= sel_op;
          a_r   <= sel_a;
          b_r   <= sel_b;
          tag_r <= sel_tag;
          src_r <= grant;
          if (illegal) begin
            data_r <= 32'd0;
            err_r  <= 1'b1;
          end else if (div0) begin
            data_r <= 32'hFFFF_FFFF;
            err_r  <= 1'b1;
          end else begin
            cnt   <= (sel_op == 3'b100) ? CNT_W'(DIV_LAT - 1) : CNT_W'(ALU_LAT - 1);
            err_r <= 1'b0;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            data_r <= alu_result;
            err_r  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ALU and write-back outputs are forced to 0 outside their own phase.
  assign alu_enable = (state == EXEC);
  assign alu_sel    = alu_enable ? op_r : 3'd0;
  assign alu_op_a   = alu_enable ? a_r  : 32'd0;
  assign alu_op_b   = alu_enable ? b_r  : 32'd0;

  assign wb_valid = (state == RESP);
  assign wb_data  = wb_valid ? data_r : 32'd0;
  assign wb_tag   = wb_valid ? tag_r  : '0;
  assign wb_src   = wb_valid & src_r;
  assign wb_err   = wb_valid & err_r;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_k_alu_sched.sv
// Directed table-driven bench for k_alu_sched with a behavioural ALU model.
// Grant expectations follow K_ALU_SCHED_FIXED_PRIO_EN when it is defined.
module tb_k_alu_sched;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op, alu_sel;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_tag, req1_tag, wb_tag;
  logic        alu_enable, wb_valid, wb_ready, wb_src, wb_err, busy;
  logic [31:0] alu_op_a, alu_op_b, alu_result, wb_data;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int both_ready = 0;

  k_alu_sched #(.TAG_W(4), .ALU_LAT(1), .DIV_LAT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .alu_sel(alu_sel), .alu_enable(alu_enable), .alu_op_a(alu_op_a),
    .alu_op_b(alu_op_b), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_tag(wb_tag), .wb_src(wb_src), .wb_err(wb_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock and ALU model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_result = 32'd0;
    case (alu_sel)
      3'b000: alu_result = alu_op_a + alu_op_b;
      3'b001: alu_result = alu_op_a & alu_op_b;
      3'b010: alu_result = alu_op_b >> 8;
      3'b011: alu_result = alu_op_b >> 16;
      3'b100: alu_result = (alu_op_b != 0) ? alu_op_a / alu_op_b : 32'd0;
      3'b101: alu_result = alu_op_a - alu_op_b;
      default: alu_result = 32'd0;
    endcase
  end

  always @(negedge clk) begin
    #1;
    if (req0_ready && req1_ready) both_ready++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        src;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_en;
  } vec_t;

  vec_t vecs[10];

  task automatic drive_req(input logic src, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    if (!src) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
    end
  endtask

  // Present a request at a negedge; returns at the negedge after its handshake.
  task automatic issue(input logic src, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag, input string name);
    bit got = 0;
    @(negedge clk);
    drive_req(src, op, a, b, tag);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (src ? req1_ready : req0_ready) got = 1;
      else @(negedge clk);
    end
    chk({name, "_accept"}, 32'(got), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int en_cnt = 0;
    int lat = 0;
    int bad = 0;
    bit got = 0;
    string nm;
    nm = $sformatf("v%0d", idx);
    wb_ready = 1'b1;
    issue(v.src, v.op, v.a, v.b, v.tag, nm);
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      lat++;
      if (alu_enable) begin
        en_cnt++;
        if (alu_sel !== v.op || alu_op_a !== v.a || alu_op_b !== v.b) bad++;
      end else if (alu_sel !== 3'd0 || alu_op_a !== 32'd0 || alu_op_b !== 32'd0) begin
        bad++;
      end
      if (wb_valid) got = 1;
      else @(negedge clk);
    end
    chk({nm, "_wb_valid"}, 32'(got), 32'd1);
    chk({nm, "_data"}, wb_data, v.exp_data);
    chk({nm, "_err"}, 32'(wb_err), 32'(v.exp_err));
    chk({nm, "_tag"}, 32'(wb_tag), 32'(v.tag));
    chk({nm, "_src"}, 32'(wb_src), 32'(v.src));
    chk({nm, "_en_cycles"}, 32'(en_cnt), 32'(v.exp_en));
    chk({nm, "_latency"}, 32'(lat), 32'(v.exp_en + 1));
    chk({nm, "_alu_drive"}, 32'(bad), 32'd0);
    @(negedge clk);
    #1;
    chk({nm, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cnt_bad;
    int grants[4];
    int exp_g[4];
    int ng;
    logic [3:0] held_tag;

    vecs[0] = '{1'b0, 3'b000, 32'd5,          32'd7,          4'd3,  32'd12,         1'b0, 1};
    vecs[1] = '{1'b1, 3'b001, 32'hF0F0_1234,  32'h0FF0_FF00,  4'd5,  32'h00F0_1200,  1'b0, 1};
    vecs[2] = '{1'b0, 3'b010, 32'd0,          32'h1234_5678,  4'd6,  32'h0012_3456,  1'b0, 1};
    vecs[3] = '{1'b1, 3'b011, 32'd9,          32'hDEAD_BEEF,  4'd7,  32'h0000_DEAD,  1'b0, 1};
    vecs[4] = '{1'b1, 3'b100, 32'd100,        32'd7,          4'd8,  32'd14,         1'b0, 16};
    vecs[5] = '{1'b1, 3'b100, 32'd100,        32'd0,          4'd9,  32'hFFFF_FFFF,  1'b1, 0};
    vecs[6] = '{1'b0, 3'b101, 32'd3,          32'd5,          4'd10, 32'hFFFF_FFFE,  1'b0, 1};
    vecs[7] = '{1'b0, 3'b111, 32'd1,          32'd2,          4'd11, 32'd0,          1'b1, 0};
    vecs[8] = '{1'b1, 3'b110, 32'd1,          32'd2,          4'd12, 32'd0,          1'b1, 0};
    vecs[9] = '{1'b0, 3'b000, 32'hFFFF_FFFF,  32'd2,          4'd13, 32'd1,          1'b0, 1};

    // Reset
    rst_n = 1'b0; wb_ready = 1'b0;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0; req0_tag = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
    #1;
    chk("rst_alu_outs", 32'(|{alu_enable, alu_sel, alu_op_a, alu_op_b}), 32'd0);
    chk("rst_wb_outs", 32'(|{wb_valid, wb_data, wb_tag, wb_src, wb_err}), 32'd0);
    chk("rst_ctrl_outs", 32'(|{busy, req0_ready, req1_ready, dbg_state}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Illegal op with write-back backpressure
    wb_ready = 1'b0;
    issue(1'b0, 3'b111, 32'd4, 32'd4, 4'd14, "hold");
    req1_valid = 1'b1; req1_op = 3'b000; req1_a = 1; req1_b = 1; req1_tag = 4'd1;
    held_tag = 4'd14;
    for (int i = 0; i < 5; i++) begin
      #1;
      cnt_bad = 0;
      if (!wb_valid || wb_data !== 32'd0 || !wb_err || wb_tag !== held_tag || wb_src !== 1'b0) cnt_bad++;
      if (!busy || req0_ready || req1_ready || alu_enable) cnt_bad++;
      chk($sformatf("hold_c%0d", i), 32'(cnt_bad), 32'd0);
      @(negedge clk);
    end
    req1_valid = 1'b0;
    wb_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("hold_release_idle", 32'(busy), 32'd0);

    // Reset in the middle of a divide
    issue(1'b1, 3'b100, 32'd100, 32'd7, 4'd2, "rstdiv");
    repeat (4) @(negedge clk);
    #1;
    chk("rstdiv_in_exec", 32'(alu_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstdiv_alu_outs", 32'(|{alu_enable, alu_sel, alu_op_a, alu_op_b}), 32'd0);
    chk("rstdiv_wb_outs", 32'(|{wb_valid, wb_data, wb_tag, wb_src, wb_err, busy}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (wb_valid || busy) cnt_bad++;
    end
    chk("rstdiv_no_stale_wb", 32'(cnt_bad), 32'd0);

    // Contended adds: both requesters valid until four grants are seen
`ifdef K_ALU_SCHED_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    @(negedge clk);
    drive_req(1'b0, 3'b000, 32'd1, 32'd2, 4'd4);
    drive_req(1'b1, 3'b000, 32'd3, 32'd4, 4'd5);
    wb_ready = 1'b1;
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      #1;
      if (req0_ready) begin grants[ng] = 0; ng++; end
      else if (req1_ready) begin grants[ng] = 1; ng++; end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < ng) chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
    repeat (4) @(negedge clk);
    chk("never_both_ready", 32'(both_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/k_alu_sched.md
Name: k_alu_sched

Overview:
- Sequencer/arbiter sharing one K-series 32-bit ALU between two requesters (req0, req1).
- Accepts one operation at a time via a valid/ready handshake, arbitrates round-robin, and decodes and rejects illegal/divide-by-zero ops.
- Drives the ALU select, enable and operands; waits the op-dependent latency; returns result, tag and error on a write-back port with backpressure.

Parameters:
- TAG_W, 4, width of request/write-back tag.
- ALU_LAT, 1, cycles ALU enable held for ops 000/001/010/011/101 (>=1).
- DIV_LAT, 16, cycles ALU enable held for divide op 100 (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  scheduler accepts requester 0 this cycle.
- req0_op  in  3  opcode: 000 add, 001 and, 010 B>>8, 011 B>>16, 100 A/B, 101 A-B, 110/111 illegal.
- req0_a  in  32  operand A.
- req0_b  in  32  operand B.
- req0_tag  in  TAG_W  returned unchanged on write-back.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_tag: same as req0 for requester 1.
- alu_sel  out  3  ALU selector.
- alu_enable  out  1  ALU operation active.
- alu_op_a  out  32  ALU operand A.
- alu_op_b  out  32  ALU operand B.
- alu_result  in  32  ALU result, valid on the last EXEC cycle.
- wb_valid  out  1  write-back data valid.
- wb_ready  in  1  write-back consumer accepts.
- wb_data  out  32  result.
- wb_tag  out  TAG_W  tag of the completed op.
- wb_src  out  1  requester index of the completed op.
- wb_err  out  1  op was illegal or divide-by-zero.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; cnt 0; last_grant=1, so req0 wins first.
- States: IDLE, EXEC, RESP.
- IDLE, grant selection:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant !last_grant.
  - reqN_ready is combinational, high only for the granted requester and only in IDLE; never high for both requesters.
- IDLE, on handshake (valid & ready): latch op/a/b/tag/src, update last_grant, then:
  - op 110/111: go to RESP; wb_err=1, wb_data=0; ALU untouched.
  - op 100 with b==0: go to RESP; wb_err=1, wb_data=32'hFFFF_FFFF; ALU untouched.
  - otherwise: go to EXEC; cnt = (op==100 ? DIV_LAT : ALU_LAT) - 1.
- EXEC:
  - alu_enable=1; alu_sel/alu_op_a/alu_op_b driven from registers, stable the whole phase.
  - cnt decrements each cycle.
  - On cnt==0: capture alu_result into wb_data, wb_err=0, go to RESP.
- RESP:
  - wb_valid=1; wb_data/tag/src/err held stable until wb_valid & wb_ready, then return to IDLE.
  - alu_enable=0 and alu_sel/op outputs return to 0 outside EXEC.
- Latency (handshake in cycle T, wb_ready=1):
  - simple op: EXEC cycles T+1..T+ALU_LAT, wb_valid at T+ALU_LAT+1.
  - illegal or div0: wb_valid at T+1.
  - earliest next accept: cycle after wb handshake. Throughput is one op per LAT+2 cycles.
- Request inputs are ignored outside IDLE; requesters must hold valid and payload until ready.
- Reset mid-operation: the op is discarded, no write-back is issued, and arbitration restarts with req0 priority.
- Widths: operands and result 32 bits; arithmetic and wrap-around are performed by the ALU; the scheduler never modifies data.

Optional Feature:
- Macro: K_ALU_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; req0 always wins when both are valid; last_grant is unused.
- Undefined: round-robin as described above.

Test Plan:
- req0 add a=5 b=7 tag=3, wb_ready=1 -> alu_enable=1 for 1 cycle with alu_sel=000; wb_valid 2 cycles after handshake; wb_data=12, wb_tag=3, wb_src=0, wb_err=0.
- req0 and req1 both valid continuously with op add, 4 ops -> grants alternate 0,1,0,1; never two readies high in the same cycle.
- req1 div a=100 b=7 with DIV_LAT=16 -> alu_enable high exactly 16 cycles; wb_data=14. Then div b=0 -> wb_valid next cycle, wb_data=FFFF_FFFF, wb_err=1, alu_enable stays 0.
- op=111 -> wb_err=1, wb_data=0, no ALU enable. Then wb_ready=0 for 5 cycles -> wb_valid held with stable payload, busy=1, no req ready asserted.
- Assert rst_n=0 mid-EXEC of a divide -> all outputs 0 immediately; after release no stale write-back; next contended grant goes to req0.
- With K_ALU_SCHED_FIXED_PRIO_EN defined, both requesters valid continuously -> req0 granted every time.
